// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and decodes the datapath strobes from the current state.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       rd_we,
  output logic [1:0] rd_src,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t state_q, state_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;

  logic is_lui, is_auipc, is_jal, is_jalr, is_opimm, is_op;
  logic is_load, is_store, is_branch, is_system, is_legal;
  logic use_pc_a, use_imm_b;

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_system = (opcode == OPC_SYSTEM);
  assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_opimm | is_op |
                     is_load | is_store | is_branch;

  assign use_pc_a  = is_auipc | is_jal | is_branch;
  assign use_imm_b = is_opimm | is_load | is_store | is_jalr | is_auipc | is_jal | is_branch;

  // Next-state and strobe decode; reset overrides every strobe and select to zero.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rd_we     = 1'b0;
    rd_src    = 2'd0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state_d = S_EXEC;
          end else if (is_system) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            illegal_d = 1'b1;
          end
        end
        S_EXEC: begin
          alu_a_sel = use_pc_a;
          alu_b_sel = use_imm_b;
          if (is_branch) begin
            pc_we   = 1'b1;
            pc_src  = branch_taken ? 2'd1 : 2'd0;
            state_d = S_FETCH;
          end else if (is_jal || is_jalr) begin
            // Link register takes PC+4 on the same edge the PC jumps.
            rd_we   = 1'b1;
            rd_src  = 2'd2;
            pc_we   = 1'b1;
            pc_src  = is_jal ? 2'd1 : 2'd2;
            state_d = S_FETCH;
          end else if (is_load || is_store) begin
            state_d = S_MEM;
          end else if (is_op || is_opimm || is_lui || is_auipc) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          mem_req   = 1'b1;
          addr_sel  = 1'b1;
          mem_we    = is_store;
          alu_a_sel = use_pc_a;
          alu_b_sel = use_imm_b;
          if (!mem_ready) begin
            state_d = S_MEM;
          end else if (is_store) begin
            pc_we   = 1'b1;
            pc_src  = 2'd0;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          // Operands stay selected so the unregistered ALU result is still valid.
          alu_a_sel = use_pc_a;
          alu_b_sel = use_imm_b;
          rd_we     = 1'b1;
          pc_we     = 1'b1;
          pc_src    = 2'd0;
          rd_src    = is_load ? 2'd1 : (is_lui ? 2'd3 : 2'd0);
          state_d   = S_FETCH;
        end
        S_HALT: begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end else begin
      state_d   = S_FETCH;
      halted_d  = 1'b0;
      illegal_d = 1'b0;
    end
  end

  // State and sticky status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds the expected per-cycle trace of each
// instruction from the sequencing rules, then replays and compares it.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
  logic [1:0] pc_src, rd_src;
  logic       alu_a_sel, alu_b_sel, rd_we, halted, illegal;
  logic [2:0] state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .rd_we(rd_we), .rd_src(rd_src), .halted(halted),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, OPIMM = 7'b0010011, OPR = 7'b0110011;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] SYS = 7'b1110011, BAD = 7'b0001011;

  typedef struct packed {
    logic       rst, mr, bt;
    logic [6:0] op;
    logic       cs;
    logic [2:0] st;
    logic       req, we, asel, irwe, pcwe;
    logic [1:0] pcs;
    logic       cab, a, b, rdwe;
    logic [1:0] rds;
    logic       cstk, hlt, ill;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  logic cur_valid = 1'b0;
  logic m_halted = 1'b0, m_illegal = 1'b0;
  int   checks = 0, failures = 0, cycle = 0;
  int   n_ir = 0, n_pc = 0, n_rd = 0;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cycle, act, exp);
    end
  endtask

  function automatic logic legal(input logic [6:0] op);
    return op == LUI || op == AUIPC || op == JAL || op == JALR || op == OPIMM ||
           op == OPR || op == LOAD || op == STORE || op == BRANCH;
  endfunction

  function automatic rec_t base(input logic [6:0] op, input logic bt, input logic [2:0] st);
    rec_t r;
    r = '0;
    r.op = op; r.bt = bt; r.st = st; r.mr = 1'b1;
    r.cs = 1'b1; r.cab = 1'b1; r.cstk = 1'b1;
    r.hlt = m_halted; r.ill = m_illegal;
    return r;
  endfunction

  task automatic push_reset(input logic mr);
    rec_t r;
    r = '0;
    r.rst = 1'b1; r.mr = mr; r.cab = 1'b1;
    q.push_back(r);
    m_halted = 1'b0;
    m_illegal = 1'b0;
  endtask

  // Expected trace of one instruction: fetch waits, fetch, decode, then by class.
  task automatic add_instr(input logic [6:0] op, input logic bt, input int fw,
                           input int mw, input logic abort, output int len);
    rec_t r;
    logic a, b;
    int   start;
    start = q.size();
    for (int i = 0; i < fw; i++) begin
      r = base(op, bt, 3'd0); r.mr = 1'b0; r.req = 1'b1; q.push_back(r);
    end
    r = base(op, bt, 3'd0); r.req = 1'b1; r.irwe = 1'b1; q.push_back(r);
    r = base(op, bt, 3'd1); q.push_back(r);
    if (!legal(op)) begin
      m_halted = 1'b1;
      if (op != SYS) m_illegal = 1'b1;
      for (int i = 0; i < 11; i++) begin
        r = base(op, 1'b1, 3'd5); q.push_back(r);
      end
      len = q.size() - start;
      return;
    end
    a = (op == AUIPC) || (op == JAL) || (op == BRANCH);
    b = !((op == OPR) || (op == LUI));
    r = base(op, bt, 3'd2); r.a = a; r.b = b;
    if (op == BRANCH) begin
      r.pcwe = 1'b1; r.pcs = bt ? 2'd1 : 2'd0;
    end else if (op == JAL || op == JALR) begin
      r.rdwe = 1'b1; r.rds = 2'd2; r.pcwe = 1'b1; r.pcs = (op == JAL) ? 2'd1 : 2'd2;
    end
    q.push_back(r);
    if (op == LOAD || op == STORE) begin
      for (int i = 0; i < mw; i++) begin
        r = base(op, bt, 3'd3); r.mr = 1'b0; r.req = 1'b1; r.asel = 1'b1;
        r.we = (op == STORE); r.a = a; r.b = b; q.push_back(r);
      end
      if (abort) begin
        push_reset(1'b1);
        len = q.size() - start;
        return;
      end
      r = base(op, bt, 3'd3); r.req = 1'b1; r.asel = 1'b1;
      r.we = (op == STORE); r.a = a; r.b = b;
      if (op == STORE) r.pcwe = 1'b1;
      q.push_back(r);
    end
    if (!(op == BRANCH || op == JAL || op == JALR || op == STORE)) begin
      r = base(op, bt, 3'd4); r.cab = 1'b0; r.rdwe = 1'b1; r.pcwe = 1'b1;
      r.rds = (op == LOAD) ? 2'd1 : ((op == LUI) ? 2'd3 : 2'd0);
      q.push_back(r);
    end
    len = q.size() - start;
  endtask

  // Compare process: checks every output field of the current expected cycle.
  always @(negedge clk) begin
    #2;
    if (cur_valid) begin
      chk("mem_req", {2'b0, mem_req}, {2'b0, cur.req});
      chk("mem_we", {2'b0, mem_we}, {2'b0, cur.we});
      chk("addr_sel", {2'b0, addr_sel}, {2'b0, cur.asel});
      chk("ir_we", {2'b0, ir_we}, {2'b0, cur.irwe});
      chk("pc_we", {2'b0, pc_we}, {2'b0, cur.pcwe});
      chk("pc_src", {1'b0, pc_src}, {1'b0, cur.pcs});
      chk("rd_we", {2'b0, rd_we}, {2'b0, cur.rdwe});
      chk("rd_src", {1'b0, rd_src}, {1'b0, cur.rds});
      if (cur.cs) chk("state", state, cur.st);
      if (cur.cab) begin
        chk("alu_a_sel", {2'b0, alu_a_sel}, {2'b0, cur.a});
        chk("alu_b_sel", {2'b0, alu_b_sel}, {2'b0, cur.b});
      end
      if (cur.cstk) begin
        chk("halted", {2'b0, halted}, {2'b0, cur.hlt});
        chk("illegal", {2'b0, illegal}, {2'b0, cur.ill});
      end
      if (ir_we) n_ir++;
      if (pc_we) n_pc++;
      if (rd_we) n_rd++;
    end
  end

  initial begin
    rec_t r;
    int   len;
    push_reset(1'b0);
    push_reset(1'b0);
    // Reset arrives during a fetch wait; the ready in the reset cycle is dropped.
    r = base(OPR, 1'b1, 3'd0); r.mr = 1'b0; r.req = 1'b1; q.push_back(r);
    push_reset(1'b0);
    push_reset(1'b1);
    add_instr(OPR, 1'b1, 0, 0, 1'b0, len);    chk("len_op", len[2:0], 3'd4);
    add_instr(LOAD, 1'b1, 0, 2, 1'b0, len);   chk("len_load_w2", len[2:0], 3'd7);
    add_instr(STORE, 1'b1, 0, 0, 1'b0, len);  chk("len_store", len[2:0], 3'd4);
    add_instr(BRANCH, 1'b1, 0, 0, 1'b0, len); chk("len_br_taken", len[2:0], 3'd3);
    add_instr(BRANCH, 1'b0, 0, 0, 1'b0, len); chk("len_br_not", len[2:0], 3'd3);
    add_instr(JAL, 1'b1, 2, 0, 1'b0, len);
    add_instr(JALR, 1'b0, 0, 0, 1'b0, len);   chk("len_jalr", len[2:0], 3'd3);
    add_instr(OPIMM, 1'b1, 0, 0, 1'b0, len);
    add_instr(LUI, 1'b1, 1, 0, 1'b0, len);
    add_instr(AUIPC, 1'b0, 0, 0, 1'b0, len);
    add_instr(STORE, 1'b0, 1, 1, 1'b0, len);
    add_instr(LOAD, 1'b1, 0, 1, 1'b1, len);   // reset abandons the MEM wait
    add_instr(OPR, 1'b0, 0, 0, 1'b0, len);
    add_instr(BAD, 1'b1, 0, 0, 1'b0, len);
    push_reset(1'b1);
    add_instr(SYS, 1'b1, 0, 0, 1'b0, len);
    push_reset(1'b0);
    add_instr(OPR, 1'b1, 0, 0, 1'b0, len);

    while (q.size() > 0) begin
      @(negedge clk);
      cur          = q.pop_front();
      reset        = cur.rst;
      mem_ready    = cur.mr;
      opcode       = cur.op;
      branch_taken = cur.bt;
      cur_valid    = 1'b1;
      cycle++;
    end
    @(negedge clk);
    cur_valid = 1'b0;
    #5;
    chk("total_ir_we", n_ir[2:0], 3'd0);
    chk("total_pc_we", n_pc[2:0], 3'd5);
    chk("total_rd_we", n_rd[2:0], 3'd1);
    if (n_ir != 16 || n_pc != 13 || n_rd != 9) begin
      failures++;
      $display("FAIL pulse_totals actual=%0d/%0d/%0d required=16/13/9", n_ir, n_pc, n_rd);
    end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
